bcedn_adapter_stream: RTL and testbench

- Parametrised full-precision adapter stage for the B-CEDNet front end: converts fixed-point receptive windows into binary feature bits for the binary layers downstream.
- Accepts one FH*FW*D window per valid/ready beat and evaluates FD filters in FD/N_PE groups on N_PE parallel MAC lanes.
- Each filter is thresholded against a per-filter norm reference with optional polarity flip. Results are packed into an FD-bit word with out_valid/out_ready backpressure.
- Counts windows per frame and pulses tg_next at frame end.

---
 rtl/bcedn_adapter_pkg.sv | 33 +++
 rtl/bcedn_adapter_coef_rom.sv | 30 +++
 rtl/bcedn_adapter_stream.sv | 187 ++++++++++++++++++
 tb/tb_bcedn_adapter_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcedn_adapter_pkg.sv
// Shared types and helpers for the B-CEDNet full-precision adapter stage.
package bcedn_adapter_pkg;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Per-lane ROM field layout, LSB first: flip bit, then ref, then the
    // K weights with weight 0 in the most significant DW bits.
    localparam int FLIP_OFS = 0;
    localparam int REF_OFS  = 1;

    function automatic int lane_width(input int k, input int dw, input int acc_w);
        return k * dw + acc_w + 1;
    endfunction

endpackage

// File: rtl/bcedn_adapter_coef_rom.sv
// Coefficient ROM: one entry per filter group, contents fixed at elaboration,
// registered 1-cycle read.
module adapter_coef_rom
    import bcedn_adapter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 68,
    parameter int AW    = 1,
    parameter logic [DEPTH*WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    i_addr,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    // Registered read of entry i_addr; entry g sits at bits [g*WIDTH +: WIDTH].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else begin
            r_data <= INIT[i_addr*WIDTH +: WIDTH];
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/bcedn_adapter_stream.sv
// Full-precision adapter: evaluates FD thresholded filters over one window in
// FD/N_PE groups on N_PE MAC lanes and emits an FD-bit binary feature word.
module bcedn_adapter_stream
    import bcedn_adapter_pkg::*;
#(
    parameter int FH            = 3,
    parameter int FW            = 3,
    parameter int D             = 1,
    parameter int FD            = 128,
    parameter int N_PE          = 4,
    parameter int DW            = 8,
    parameter int FRAME_WINDOWS = 4096,
    // Coefficient image: entry g at [g*ENTRY_W +: ENTRY_W], lane 0 in the
    // top LANE_W bits of each entry.
    parameter logic [FD*(FH*FW*D*DW + 2*DW + clog2(FH*FW*D) + 1)-1:0] COEF_INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FH*FW*D*DW-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FD-1:0]          out_data,
    output logic                   tg_next,
    output logic                   busy
);

    localparam int K        = FH * FW * D;
    localparam int G        = FD / N_PE;
    localparam int ACC_W    = 2 * DW + clog2(K);
    localparam int LANE_W   = lane_width(K, DW, ACC_W);
    localparam int ENTRY_W  = N_PE * LANE_W;
    localparam int GW       = (G > 1) ? clog2(G) : 1;
    localparam int CNT_W    = clog2(FRAME_WINDOWS + 1);
    localparam logic [GW-1:0]    GRP_LAST = GW'(G - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WINDOWS - 1);

    state_t             r_state;
    logic [GW-1:0]      r_grp;
    logic               r_drain;
    logic [K*DW-1:0]    r_win;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [FD-1:0]      r_out_data;
    logic [FD-1:0]      r_stage;
    logic               r_rom_vld;
    logic [GW-1:0]      r_rom_grp;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tg;

    logic [ENTRY_W-1:0]      w_rom_q;
    logic signed [2*DW-1:0]  w_prod [N_PE][K];
    logic signed [ACC_W-1:0] w_acc  [N_PE];
    logic signed [ACC_W-1:0] w_ref  [N_PE];
    logic [N_PE-1:0]         w_bit;
    logic                    w_hs;

    adapter_coef_rom #(
        .DEPTH (G),
        .WIDTH (ENTRY_W),
        .AW    (GW),
        .INIT  (COEF_INIT)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr (r_grp),
        .o_data (w_rom_q)
    );

    assign w_hs = r_out_valid && out_ready;

    // Window control: accept, issue G group addresses, wait out the ROM and
    // compare pipeline, then hold the result until downstream takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grp       <= '0;
            r_drain     <= 1'b0;
            r_win       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_in_ready && in_valid) begin
                        r_win      <= in_data;
                        r_grp      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_grp == GRP_LAST) begin
                        r_grp   <= '0;
                        r_drain <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_stage;
                        r_state     <= OUT;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag each ROM word with the group it belongs to, one cycle behind the address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rom_vld <= 1'b0;
            r_rom_grp <= '0;
        end else begin
            r_rom_vld <= (r_state == RUN);
            r_rom_grp <= r_grp;
        end
    end

    // MAC and threshold per lane: signed sum of products against ref, optional flip.
    always_comb begin
        w_bit = '0;
        for (int i = 0; i < N_PE; i++) begin
            w_acc[i] = '0;
            w_ref[i] = $signed(w_rom_q[(N_PE-1-i)*LANE_W + REF_OFS +: ACC_W]);
            for (int k = 0; k < K; k++) begin
                w_prod[i][k] = $signed(r_win[K*DW-1-k*DW -: DW])
                             * $signed(w_rom_q[(N_PE-1-i)*LANE_W + LANE_W-1-k*DW -: DW]);
                w_acc[i] = w_acc[i] + ACC_W'(w_prod[i][k]);
            end
            w_bit[i] = (w_acc[i] >= w_ref[i]) ^ w_rom_q[(N_PE-1-i)*LANE_W + FLIP_OFS];
        end
    end

    // Staging register: filter f = grp*N_PE + lane lands at bit FD-1-f.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage <= '0;
        end else if (r_rom_vld) begin
            for (int f = 0; f < FD; f++) begin
                if (r_rom_grp == GW'(f / N_PE)) begin
                    r_stage[FD-1-f] <= w_bit[f % N_PE];
                end
            end
        end
    end

    // Frame window counter; start clears it, tg_next marks the completing handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_tg  <= 1'b0;
        end else begin
            r_tg <= w_hs && (r_cnt == CNT_LAST);
            if (start) begin
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign tg_next   = r_tg;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bcedn_adapter_stream.sv
// Directed bench for bcedn_adapter_stream with a 2-element window, 4 filters
// on 2 lanes (2 groups) and 3-window frames.
module tb_bcedn_adapter_stream;

    // Lane layout: {w0[7:0], w1[7:0], ref[16:0], flip}
    localparam logic [33:0] F0 = {8'd1, 8'd1,   17'd0,  1'b0};
    localparam logic [33:0] F1 = {8'd1, 8'hFF,  17'd0,  1'b0};
    localparam logic [33:0] F2 = {8'd2, 8'd0,   17'd10, 1'b0};
    localparam logic [33:0] F3 = {8'd1, 8'd1,   17'd0,  1'b1};
    localparam logic [135:0] INIT = {F2, F3, F0, F1};
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        tg_next;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;

    typedef struct {
        logic [15:0] win;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs [6];

    bcedn_adapter_stream #(
        .FH(1), .FW(1), .D(2), .FD(4), .N_PE(2), .DW(8),
        .FRAME_WINDOWS(3), .COEF_INIT(INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .tg_next   (tg_next),
        .busy      (busy)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present a window until accepted; leaves us #1 after the accept edge.
    task automatic accept(input logic [15:0] win);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("in_ready_wait", {31'd0, in_ready}, 1);
        in_valid = 1'b1;
        in_data  = win;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    // Count cycles from the accept cycle until out_valid is seen.
    task automatic wait_out(output logic [3:0] got, output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            check("in_ready_low_busy", {31'd0, in_ready}, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_rise", {31'd0, out_valid}, 1);
        got = out_data;
    endtask

    // Complete a handshake (out_ready assumed 1) and check the frame model.
    task automatic finish_hs(input logic do_start);
        logic exp_tg;
        start = do_start;
        @(posedge clk); #1;
        start = 1'b0;
        exp_tg = (m_cnt == 2);
        m_cnt  = (do_start || m_cnt == 2) ? 0 : m_cnt + 1;
        check("tg_next_hs", {31'd0, tg_next}, {31'd0, exp_tg});
        check("post_hs_idle", {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_cnt = 0;
        check("tg_next_start", {31'd0, tg_next}, 0);
    endtask

    task automatic run_vec(input string name, input logic [15:0] win, input logic [3:0] exp);
        logic [3:0] got;
        int lat;
        accept(win);
        wait_out(got, lat);
        check({name, "_data"}, {28'd0, got}, {28'd0, exp});
        check({name, "_lat"}, lat, LAT);
        finish_hs(1'b0);
    endtask

    initial begin
        logic [3:0] got;
        int lat;
        logic ok;

        vecs[0] = '{win: {8'd5,   8'd3},   exp: 4'b1110};
        vecs[1] = '{win: {8'hFC,  8'd2},   exp: 4'b0001};
        vecs[2] = '{win: {8'd0,   8'd0},   exp: 4'b1100};
        vecs[3] = '{win: {8'd127, 8'h80},  exp: 4'b0111};
        vecs[4] = '{win: {8'h80,  8'h80},  exp: 4'b0101};
        vecs[5] = '{win: {8'd1,   8'd2},   exp: 4'b1000};

        // reset
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", {28'd0, out_data}, 0);
        check("rst_tg_next", {31'd0, tg_next}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", {31'd0, in_ready}, 1);

        // table vectors (6 handshakes: frame ends on 3rd and 6th)
        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].win, vecs[i].exp);
        end

        // frame boundary: 3 windows pulse once, pulse lasts one cycle, 4th silent
        pulse_start();
        for (int i = 0; i < 3; i++) run_vec($sformatf("frame_a%0d", i), vecs[i].win, vecs[i].exp);
        @(posedge clk); #1;
        check("tg_next_one_cycle", {31'd0, tg_next}, 0);
        run_vec("frame_a3", vecs[3].win, vecs[3].exp);

        // start after 2 handshakes restarts the frame
        pulse_start();
        run_vec("frame_b0", vecs[0].win, vecs[0].exp);
        run_vec("frame_b1", vecs[1].win, vecs[1].exp);
        pulse_start();
        for (int i = 0; i < 3; i++) run_vec($sformatf("frame_c%0d", i), vecs[i + 2].win, vecs[i + 2].exp);

        // start coinciding with a non-final handshake clears without a pulse
        run_vec("frame_d0", vecs[5].win, vecs[5].exp);
        accept(vecs[0].win);
        wait_out(got, lat);
        check("start_hs_data", {28'd0, got}, {28'd0, vecs[0].exp});
        finish_hs(1'b1);
        for (int i = 0; i < 3; i++) run_vec($sformatf("frame_e%0d", i), vecs[i].win, vecs[i].exp);

        // backpressure
        out_ready = 1'b0;
        accept(vecs[5].win);
        wait_out(got, lat);
        check("bp_data", {28'd0, got}, {28'd0, vecs[5].exp});
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!(out_valid === 1'b1 && out_data === got && in_ready === 1'b0 && tg_next === 1'b0)) ok = 1'b0;
        end
        check("bp_hold", {31'd0, ok}, 1);
        out_ready = 1'b1;
        finish_hs(1'b0);

        // reset during DRAIN
        accept(vecs[1].win);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drain_busy", {30'd0, busy, out_valid}, 32'b10);
        rst = 1'b0;
        #1;
        check("drain_rst_out_valid", {31'd0, out_valid}, 0);
        check("drain_rst_busy", {31'd0, busy}, 0);
        check("drain_rst_out_data", {28'd0, out_data}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        m_cnt = 0;
        @(posedge clk); #1;
        check("drain_rel_in_ready", {31'd0, in_ready}, 1);
        run_vec("post_rst", vecs[0].win, vecs[0].exp);
        run_vec("post_rst2", vecs[2].win, vecs[2].exp);
        run_vec("post_rst3", vecs[4].win, vecs[4].exp);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
